// File: rtl/rock_pkg.sv
// Shared types and helpers for the rocking setpoint sequencer.
//   LEVEL_W_DEFAULT : default amplitude/frequency level width
//   seq_state_t     : sequencer FSM states
//   step_toward     : moves a level one count toward its target (never past it)
package rock_pkg;

  localparam int LEVEL_W_DEFAULT = 3;
  // Width the step helper works at; level widths up to this are supported.
  localparam int STEP_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2,
    STOP = 2'd3
  } seq_state_t;

  // One count toward tgt. Because it only ever moves toward a target that is
  // itself a legal level, it cannot wrap at either end of the range.
  function automatic logic [STEP_W-1:0] step_toward(input logic [STEP_W-1:0] cur,
                                                    input logic [STEP_W-1:0] tgt);
    if (cur < tgt)      return cur + STEP_W'(1);
    else if (cur > tgt) return cur - STEP_W'(1);
    else                return cur;
  endfunction

endpackage

// File: rtl/rock_hold_timer.sv
// Minimum-hold down-counter for a settled setpoint.
//   clk, reset : clock, async active-high reset (count clears to 0)
//   load       : load count with the reload value
//   tick       : slow-tick enable; decrements while non-zero
//   count      : reload value (ticks remaining minus one after load)
//   done       : counter has reached zero
module rock_hold_timer #(
  parameter int HOLD_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              tick,
  input  logic [HOLD_W-1:0] count,
  output logic              done
);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (load)               cnt <= count;
    else if (tick && cnt != '0)  cnt <= cnt - HOLD_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rock_setpoint_sequencer.sv
// Setpoint sequencer between the rocking controller and the output stage.
// Accepts amplitude/frequency targets, walks the driven levels one step per
// slow tick (amp down, then freq, then amp up), holds each settled setpoint
// for HOLD_TICKS ticks, and ramps both levels to zero on error or !run.
//   clk, reset          : clock, async active-high reset
//   tick                : one-clk slow-tick enable
//   run, err            : run permission / controller error (either forces STOP)
//   tgt_amp, tgt_freq   : offered target, tgt_valid/tgt_ready handshake
//   cur_amp, cur_freq   : driven levels
//   settled             : IDLE/HOLD with driven levels equal to latched target
//   stopped             : STOP with both levels at zero
// All outputs are registered; they are computed from next-state values.
module rock_setpoint_sequencer #(
  parameter int LEVEL_W    = rock_pkg::LEVEL_W_DEFAULT,
  parameter int HOLD_TICKS = 4,
  parameter int HOLD_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               run,
  input  logic               err,
  input  logic [LEVEL_W-1:0] tgt_amp,
  input  logic [LEVEL_W-1:0] tgt_freq,
  input  logic               tgt_valid,
  output logic               tgt_ready,
  output logic [LEVEL_W-1:0] cur_amp,
  output logic [LEVEL_W-1:0] cur_freq,
  output logic               settled,
  output logic               stopped
);

  import rock_pkg::*;

  seq_state_t         state, state_n;
  logic [LEVEL_W-1:0] t_amp, t_freq, ta_n, tf_n;
  logic [LEVEL_W-1:0] amp_n, freq_n;
  logic               ready_n, settled_n, stopped_n;
  logic               hold_load, hold_done;
  logic               halt;

  function automatic logic [LEVEL_W-1:0] step_lvl(input logic [LEVEL_W-1:0] c,
                                                  input logic [LEVEL_W-1:0] t);
    return LEVEL_W'(step_toward(STEP_W'(c), STEP_W'(t)));
  endfunction

  rock_hold_timer #(.HOLD_W(HOLD_W)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (hold_load),
    .tick  (tick && state == HOLD),
    .count (HOLD_W'(HOLD_TICKS - 1)),
    .done  (hold_done)
  );

  assign halt = err | ~run;

  always_comb begin
    state_n   = state;
    amp_n     = cur_amp;
    freq_n    = cur_freq;
    ta_n      = t_amp;
    tf_n      = t_freq;
    hold_load = 1'b0;

    if (state == STOP) begin
      // Ramp-down runs to completion regardless of err/run; exit only
      // once both levels are zero and the cause has cleared.
      ta_n = '0;
      tf_n = '0;
      if (cur_amp == '0 && cur_freq == '0) begin
        if (!halt) state_n = IDLE;
      end else if (tick) begin
        if (cur_amp != '0) amp_n  = cur_amp - LEVEL_W'(1);
        else               freq_n = cur_freq - LEVEL_W'(1);
      end
    end else if (halt) begin
      // Takes priority over a same-clk handshake or step.
      state_n = STOP;
      ta_n    = '0;
      tf_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tgt_valid && tgt_ready) begin
            ta_n    = tgt_amp;
            tf_n    = tgt_freq;
            state_n = RAMP;
          end
        end
        RAMP: begin
          if (tick) begin
            // Amp down first so freq never moves at an amp above the new target.
            if (cur_amp > t_amp)        amp_n  = step_lvl(cur_amp, t_amp);
            else if (cur_freq != t_freq) freq_n = step_lvl(cur_freq, t_freq);
            else if (cur_amp < t_amp)   amp_n  = step_lvl(cur_amp, t_amp);
            else begin
              state_n   = HOLD;
              hold_load = 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick && hold_done) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end

    ready_n   = (state_n == IDLE) && !halt;
    settled_n = (state_n == IDLE || state_n == HOLD) && amp_n == ta_n && freq_n == tf_n;
    stopped_n = (state_n == STOP) && amp_n == '0 && freq_n == '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_amp   <= '0;
      cur_freq  <= '0;
      t_amp     <= '0;
      t_freq    <= '0;
      tgt_ready <= 1'b0;
      settled   <= 1'b1;
      stopped   <= 1'b0;
    end else begin
      state     <= state_n;
      cur_amp   <= amp_n;
      cur_freq  <= freq_n;
      t_amp     <= ta_n;
      t_freq    <= tf_n;
      tgt_ready <= ready_n;
      settled   <= settled_n;
      stopped   <= stopped_n;
    end
  end

endmodule
